// File: rtl/exu_alu_seq.sv
// exu_alu_seq: multi-cycle ALU stage with valid/ready handshakes.
// Single-cycle ops finish at accept; arithmetic right shift iterates one bit per cycle.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`endif
`ifndef ADD
`define ADD 0
`endif
`ifndef SUB
`define SUB 1
`endif
`ifndef EQ
`define EQ 2
`endif
`ifndef NEQ
`define NEQ 3
`endif
`ifndef LESS_U
`define LESS_U 4
`endif
`ifndef XOR
`define XOR 5
`endif
`ifndef OR
`define OR 6
`endif
`ifndef SHIFT_R_A
`define SHIFT_R_A 7
`endif
`ifndef NO_FUNCT
`define NO_FUNCT 15
`endif

module exu_alu_seq #(
  parameter int ISA_WIDTH       = `ISA_WIDTH,
  parameter int ALU_FUNCT_WIDTH = `ALU_FUNCT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ISA_WIDTH-1:0]       alu_a,
  input  logic [ISA_WIDTH-1:0]       alu_b,
  input  logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ISA_WIDTH-1:0]       alu_result,
  output logic                       busy
);

  localparam logic [ALU_FUNCT_WIDTH-1:0] F_ADD = ALU_FUNCT_WIDTH'(`ADD);
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_SUB = ALU_FUNCT_WIDTH'(`SUB);
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_EQ  = ALU_FUNCT_WIDTH'(`EQ);
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_NEQ = ALU_FUNCT_WIDTH'(`NEQ);
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_LTU = ALU_FUNCT_WIDTH'(`LESS_U);
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_XOR = ALU_FUNCT_WIDTH'(`XOR);
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_OR  = ALU_FUNCT_WIDTH'(`OR);
  localparam logic [ALU_FUNCT_WIDTH-1:0] F_SRA = ALU_FUNCT_WIDTH'(`SHIFT_R_A);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ISA_WIDTH-1:0] res_q, res_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [ISA_WIDTH-1:0] calc_res;
  logic [4:0]           shamt;
  logic                 is_shift;
  logic                 unused_b_hi;

  assign shamt       = alu_b[4:0];
  assign is_shift    = (alu_funct == F_SRA);
  assign unused_b_hi = ^alu_b[ISA_WIDTH-1:5];

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign alu_result = res_q;

  // Single-cycle result; shift seeds the working register with a.
  always_comb begin
    calc_res = '0;
    case (alu_funct)
      F_ADD:   calc_res = alu_a + alu_b;
      F_SUB:   calc_res = alu_a - alu_b;
      F_EQ:    calc_res = ISA_WIDTH'(alu_a == alu_b);
      F_NEQ:   calc_res = ISA_WIDTH'(alu_a != alu_b);
      F_LTU:   calc_res = ISA_WIDTH'(alu_a < alu_b);
      F_XOR:   calc_res = alu_a ^ alu_b;
      F_OR:    calc_res = alu_a | alu_b;
      F_SRA:   calc_res = alu_a;
      default: calc_res = '0;
    endcase
  end

  // Next state: accept in IDLE, shift one bit per CALC cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          res_d = calc_res;
          if (is_shift && (shamt != 5'd0)) begin
            cnt_d   = shamt;
            state_d = CALC;
          end else begin
            state_d = DONE;
          end
        end
      end
      CALC: begin
        res_d = {res_q[ISA_WIDTH-1], res_q[ISA_WIDTH-1:1]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, result and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_exu_alu_seq.sv
// tb_exu_alu_seq: directed and random ops against an arithmetic reference.
// Checks latency, result, handshakes, backpressure and reset abort.
module tb_exu_alu_seq;

  localparam logic [3:0] C_ADD = 4'd0;
  localparam logic [3:0] C_SUB = 4'd1;
  localparam logic [3:0] C_EQ  = 4'd2;
  localparam logic [3:0] C_NEQ = 4'd3;
  localparam logic [3:0] C_LTU = 4'd4;
  localparam logic [3:0] C_XOR = 4'd5;
  localparam logic [3:0] C_OR  = 4'd6;
  localparam logic [3:0] C_SRA = 4'd7;
  localparam logic [3:0] C_NOF = 4'd15;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_funct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  exu_alu_seq #(
    .ISA_WIDTH(32),
    .ALU_FUNCT_WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_funct  (alu_funct),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0]  f);
    logic [4:0] n;
    n = b[4:0];
    case (f)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_EQ:    return (a == b) ? 32'd1 : 32'd0;
      C_NEQ:   return (a != b) ? 32'd1 : 32'd0;
      C_LTU:   return (a < b) ? 32'd1 : 32'd0;
      C_XOR:   return a ^ b;
      C_OR:    return a | b;
      C_SRA:   return $unsigned($signed(a) >>> n);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] b,
                                   input logic [3:0]  f);
    logic [4:0] n;
    n = b[4:0];
    if (f == C_SRA && n != 5'd0) return int'(n) + 1;
    return 1;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input int hold);
    logic [31:0] er;
    int el;
    int lat;
    er = model_res(a, b, f);
    el = model_lat(b, f);
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    in_valid  = 1'b1;
    alu_a     = a;
    alu_b     = b;
    alu_funct = f;
    out_ready = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      alu_a     = $urandom;
      alu_b     = $urandom;
      alu_funct = 4'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      if (!out_valid) out_ready = 1'($urandom_range(0, 1));
    end while (!out_valid && lat < 40);
    out_ready = (hold == 0);
    chk("latency", lat, el);
    chk("result", alu_result, er);
    chk("done_busy", {31'b0, busy}, 32'd1);
    chk("done_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      alu_a    = $urandom;
      in_valid = 1'b1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", alu_result, er);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      if (i == hold - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("handoff_valid", {31'b0, out_valid}, 32'd0);
    chk("handoff_in_ready", {31'b0, in_ready}, 32'd1);
    chk("handoff_result", alu_result, er);
  endtask

  logic [3:0] codes [10];

  initial begin
    codes = '{C_ADD, C_SUB, C_EQ, C_NEQ, C_LTU,
              C_XOR, C_OR, C_SRA, C_NOF, 4'd12};
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_funct = '0;
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(32'hFFFF_FFFF, 32'h2, C_ADD, 0);
    run_op(32'h8000_0000, 32'h1F, C_SRA, 0);
    run_op(32'h4000_0000, 32'h20, C_SRA, 1);
    run_op(32'h1, 32'hFFFF_FFFF, C_LTU, 0);
    run_op(32'h1234, 32'h1234, C_EQ, 0);
    run_op(32'h1234, 32'h1234, C_NEQ, 0);
    run_op(32'h0, 32'h1, C_SUB, 0);
    run_op(32'hF0F0_F0F0, 32'hFFFF_0000, C_XOR, 5);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, C_NOF, 0);

    for (int k = 0; k < 24; k++) begin
      run_op($urandom, $urandom, codes[$urandom_range(0, 9)],
             $urandom_range(0, 3));
    end

    // Reset in the middle of a 10-step shift.
    @(negedge clk);
    in_valid  = 1'b1;
    alu_a     = $urandom;
    alu_b     = 32'd10;
    alu_funct = C_SRA;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("calc_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", alu_result, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_abort_valid", {31'b0, out_valid}, 32'd0);
    end

    // First accept right after reset release.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    alu_a     = 32'd5;
    alu_b     = 32'd7;
    alu_funct = C_ADD;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("first_accept_valid", {31'b0, out_valid}, 32'd1);
    chk("first_accept_result", alu_result, 32'd12);
    @(negedge clk);
    out_ready = 1'b0;
    chk("first_accept_handoff", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
